// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run/halt/step sequencer.
//   DEF_AW / DEF_DW / DEF_CNT_W : default address, instruction and counter widths
//   ST_*                        : sequencer FSM state encodings
//   CMD_*                       : host command opcodes
package cpu_seq_pkg;
  localparam int DEF_AW    = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_CNT_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_HALTED = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_STEP   = 2'd2;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_HALT    = 3'd1;
  localparam logic [2:0] CMD_RUN     = 3'd2;
  localparam logic [2:0] CMD_STEP    = 3'd3;
  localparam logic [2:0] CMD_SET_PTR = 3'd4;
  localparam logic [2:0] CMD_WRITE   = 3'd5;
  localparam logic [2:0] CMD_SET_BP  = 3'd6;
  localparam logic [2:0] CMD_CLR_BP  = 3'd7;
endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Host command channel of the sequencer (valid/ready handshake).
//   cmd_valid : host has a command
//   cmd_ready : sequencer accepts it this cycle
//   cmd_op    : opcode (CMD_* in cpu_seq_pkg)
//   cmd_data  : operand (pointer/breakpoint address in low bits, or write data)
// master = host side, slave = sequencer side.
interface cpu_seq_ctrl_if #(parameter int DW = cpu_seq_pkg::DEF_DW);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/cpu_seq_sat_cnt.sv
// Saturating up-counter.
//   clk : clock
//   clr : synchronous clear, highest priority
//   en  : count enable
//   q   : count, sticks at all-ones
module cpu_seq_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)                        q <= '0;
    else if (en && q != {W{1'b1}})  q <= q + 1'b1;
  end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// Run/halt/step sequencer and program loader for the tiny accumulator CPU.
// Gates CPU advance via cpu_en, writes instruction memory while halted,
// optionally stops on a PC breakpoint, counts enabled CPU cycles.
//   clk, rst          : clock, synchronous active-high reset
//   cmd (slave)       : host command channel
//   cpu_pc            : current CPU program counter
//   cpu_en            : CPU may advance on this edge
//   mem_we/addr/wdata : instruction memory write port
//   halted, bp_hit    : status (bp_hit sticky until next RUN/STEP)
//   cyc_cnt           : saturating count of cpu_en cycles
// Build option: define CPU_SEQ_BREAKPOINT_EN to include breakpoint logic;
// without it SET_BP/CLR_BP behave as NOP and bp_hit is tied low.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  cpu_seq_ctrl_if.slave    cmd,
  input  logic [AW-1:0]    cpu_pc,
  output logic             cpu_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cyc_cnt
);
  state_t        state;
  logic [AW-1:0] ptr;
  logic          acc;
  logic          bp_match;

  assign cmd.cmd_ready = (state != ST_STEP);
  assign acc           = cmd.cmd_valid & cmd.cmd_ready;

`ifdef CPU_SEQ_BREAKPOINT_EN
  logic [AW-1:0] bp_addr;
  logic          bp_valid;
  logic          skip;    // first RUN cycle ignores the bp so a resume executes it

  assign bp_match = bp_valid && (cpu_pc == bp_addr) && !skip;

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_addr  <= '0;
      bp_valid <= 1'b0;
      bp_hit   <= 1'b0;
      skip     <= 1'b0;
    end else begin
      if (state == ST_RUN) skip <= 1'b0;
      if (acc && cmd.cmd_op == CMD_SET_BP) begin
        bp_addr  <= cmd.cmd_data[AW-1:0];
        bp_valid <= 1'b1;
      end
      if (acc && cmd.cmd_op == CMD_CLR_BP) bp_valid <= 1'b0;
      if (state == ST_HALTED && acc && cmd.cmd_op == CMD_RUN) begin
        skip   <= 1'b1;
        bp_hit <= 1'b0;
      end
      if (state == ST_HALTED && acc && cmd.cmd_op == CMD_STEP) bp_hit <= 1'b0;
      if (state == ST_RUN && bp_match) bp_hit <= 1'b1;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^cpu_pc;
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // STEP never looks at breakpoints; RUN yields the cycle on a match.
  assign cpu_en    = (state == ST_STEP) || (state == ST_RUN && !bp_match);
  assign mem_we    = (state == ST_HALTED) && acc && (cmd.cmd_op == CMD_WRITE);
  assign mem_addr  = ptr;
  assign mem_wdata = cmd.cmd_data;
  assign halted    = (state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HALTED;
      ptr   <= '0;
    end else begin
      case (state)
        ST_HALTED: if (acc) begin
          case (cmd.cmd_op)
            CMD_RUN:     state <= ST_RUN;
            CMD_STEP:    state <= ST_STEP;
            CMD_SET_PTR: ptr   <= cmd.cmd_data[AW-1:0];
            CMD_WRITE:   ptr   <= ptr + 1'b1;
            default: ;
          endcase
        end
        ST_RUN:  if (bp_match || (acc && cmd.cmd_op == CMD_HALT)) state <= ST_HALTED;
        ST_STEP: state <= ST_HALTED;
        default: state <= ST_HALTED;
      endcase
    end
  end

  cpu_seq_sat_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .clr (rst),
    .en  (cpu_en),
    .q   (cyc_cnt)
  );
endmodule
